// File: rtl/turn_sequencer.sv
// turn_sequencer
// Sequences one pass of the Day 1 input stage: pulses init, watches the
// header handshake, counts payload words in and out against the header
// count, drives the stage's stop input so exactly that many words are
// admitted, waits a fixed drain latency, then reports done.
// Purely an observer of the stage handshakes; never touches the data path.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start, stop held high
// INIT   | one-cycle init pulse to the input stage
// HEADER | waiting for the header transfer (not counted)
// LOAD   | header count valid on the input; latch it, payload may start
// RUN    | counting payload in/out until the announced count is admitted
// FLUSH  | all words admitted; waiting for the remaining deliveries
// DRAIN  | fixed solver latency after the last delivered word
// DONE   | pass complete, counts and done held until start/abort
module turn_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int W            = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         abort_i,
  output logic         init_o,
  output logic         stop_o,
  input  logic         in_valid_i,
  input  logic         in_ready_i,
  input  logic         out_valid_i,
  input  logic         out_ready_i,
  input  logic [W-1:0] total_num_turns_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [W-1:0] in_cnt_o,
  output logic [W-1:0] out_cnt_o
);

  // Drain timer is a down-counter loaded with DRAIN_CYCLES-1 on entry;
  // terminal count zero ends the drain.
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_HEADER,
    S_LOAD,
    S_RUN,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   total_q, total_d;
  logic [W-1:0]   in_cnt_q, in_cnt_d;
  logic [W-1:0]   out_cnt_q, out_cnt_d;
  logic           err_q, err_d;
  logic [DW-1:0]  drain_q, drain_d;

  logic           t_in, t_out;
  logic [W-1:0]   tot_eff;
  logic [W-1:0]   rem;
  logic           rem_zero, rem_one;
  logic           in_acc, out_acc;
  logic           in_last, out_last;

  // Handshake decode and count arithmetic shared by LOAD/RUN/FLUSH.
  always_comb begin
    t_in     = in_valid_i & in_ready_i;
    t_out    = out_valid_i & out_ready_i;
    // The header count only appears on the input during LOAD; afterwards
    // the latched copy is authoritative.
    tot_eff  = (state_q == S_LOAD) ? total_num_turns_i : total_q;
    rem      = tot_eff - in_cnt_q;
    rem_zero = (rem == '0);
    rem_one  = (rem == W'(1));
    // Words beyond the count are flagged as errors but never counted.
    in_acc   = t_in & ~rem_zero;
    // Deliveries stop counting once the count is reached, which keeps the
    // FLUSH exit reachable even if the stage misbehaves.
    out_acc  = t_out & (out_cnt_q != tot_eff);
    in_last  = ((in_cnt_q + W'(in_acc)) == tot_eff);
    out_last = (out_cnt_q == tot_eff) | ((out_cnt_q + W'(t_out)) == tot_eff);
  end

  // Next-state, counter updates and the combinational stage controls.
  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    err_d     = err_q;
    drain_d   = drain_q;
    init_o    = 1'b0;
    stop_o    = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_INIT;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          err_d     = 1'b0;
          drain_d   = '0;
        end
      end

      S_INIT: begin
        init_o  = 1'b1;
        stop_o  = 1'b0;
        state_d = S_HEADER;
      end

      S_HEADER: begin
        stop_o = 1'b0;
        if (t_in) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD, S_RUN: begin
        if (state_q == S_LOAD) begin
          total_d = total_num_turns_i;
        end
        // Raising stop in the same cycle as the last admitted word makes
        // the stage drop ready on that very edge.
        stop_o = rem_zero | (rem_one & t_in);
        if (in_acc) begin
          in_cnt_d = in_cnt_q + W'(1);
        end
        if (t_in & rem_zero) begin
          err_d = 1'b1;
        end
        if (out_acc) begin
          out_cnt_d = out_cnt_q + W'(1);
        end
        state_d = in_last ? S_FLUSH : S_RUN;
      end

      S_FLUSH: begin
        if (t_in) begin
          err_d = 1'b1;
        end
        if (out_acc) begin
          out_cnt_d = out_cnt_q + W'(1);
        end
        if (out_last) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end

      S_DRAIN: begin
        if (t_in) begin
          err_d = 1'b1;
        end
        if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything and freezes counters and the error flag
    // so the aborted pass can still be inspected.
    if (abort_i) begin
      state_d   = S_IDLE;
      total_d   = total_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      err_d     = err_q;
      drain_d   = drain_q;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      total_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
      drain_q   <= drain_d;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
    done_o    = (state_q == S_DONE);
    err_o     = err_q;
    in_cnt_o  = in_cnt_q;
    out_cnt_o = out_cnt_q;
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer. The bench plays the input stage (ready follows
// the previous cycle's stop, a word counter feeds the output side) and keeps
// a timestamp-based model of the pass: when init happened, when the header
// went through, when the last word was admitted and delivered, and from
// those, what every output should be in each cycle.
module tb_turn_sequencer;

  localparam int D = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i, abort_i;
  logic         init_o, stop_o;
  logic         in_valid_i, in_ready_i, out_valid_i, out_ready_i;
  logic [W-1:0] total_num_turns_i;
  logic         busy_o, done_o, err_o;
  logic [W-1:0] in_cnt_o, out_cnt_o;

  int checks   = 0;
  int failures = 0;

  // reference model
  int cyc = 0;
  bit pass_on, done_m, err_m;
  int init_c, hdr_c, in_last_c, f_c;
  int n_m, acc, del;

  // stimulus / stage environment
  int tot_drv, src_left, pending, spct, opct, hold_at, hold_left, n_init;
  bit stage_rdy, force_ld;

  turn_sequencer #(.DRAIN_CYCLES(D), .W(W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_i           (start_i),
    .abort_i           (abort_i),
    .init_o            (init_o),
    .stop_o            (stop_o),
    .in_valid_i        (in_valid_i),
    .in_ready_i        (in_ready_i),
    .out_valid_i       (out_valid_i),
    .out_ready_i       (out_ready_i),
    .total_num_turns_i (total_num_turns_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .err_o             (err_o),
    .in_cnt_o          (in_cnt_o),
    .out_cnt_o         (out_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog time limit cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pass_on = 0; done_m = 0; err_m = 0;
    init_c = -1; hdr_c = -1; in_last_c = -1; f_c = -1;
    n_m = 0; acc = 0; del = 0;
  endtask

  // One clock cycle: drive at posedge+1, check at the negedge, advance model.
  task automatic cycle();
    bit tin, tout, e_init, e_stop, e_busy, e_done, counted, rdy_n;
    int rem;
    rem = 0;
    counted = 0;
    in_ready_i  = stage_rdy | (force_ld && pass_on && hdr_c >= 0 && in_last_c < 0 && cyc == hdr_c + 1);
    in_valid_i  = (src_left > 0) && ($urandom_range(0, 99) < spct);
    out_valid_i = (pending > 0);
    out_ready_i = (hold_left == 0) && ($urandom_range(0, 99) < opct);
    if (hold_left > 0) hold_left--;
    #4;
    tin  = in_valid_i & in_ready_i;
    tout = out_valid_i & out_ready_i;

    e_init = 0; e_stop = 1; e_busy = 0; e_done = 0;
    if (!pass_on) begin
      e_done = done_m;
    end else begin
      e_busy = 1;
      if (cyc == init_c) begin
        e_init = 1; e_stop = 0;
      end else if (hdr_c < 0) begin
        e_stop = 0;
      end else if (in_last_c < 0) begin
        if (cyc == hdr_c + 1) n_m = tot_drv;
        rem = n_m - acc;
        e_stop = (rem == 0) || (rem == 1 && tin);
      end
    end

    if (init_o === 1'b1) n_init++;
    chk("init_o",    32'(init_o),    32'(e_init));
    chk("stop_o",    32'(stop_o),    32'(e_stop));
    chk("busy_o",    32'(busy_o),    32'(e_busy));
    chk("done_o",    32'(done_o),    32'(e_done));
    chk("err_o",     32'(err_o),     32'(err_m));
    chk("in_cnt_o",  32'(in_cnt_o),  acc);
    chk("out_cnt_o", 32'(out_cnt_o), del);

    if (!rst_n) begin
      model_reset();
    end else if (abort_i) begin
      pass_on = 0; done_m = 0;
    end else if (!pass_on) begin
      if (start_i) begin
        pass_on = 1; done_m = 0; err_m = 0;
        init_c = cyc + 1; hdr_c = -1; in_last_c = -1; f_c = -1;
        acc = 0; del = 0;
      end
    end else if (cyc == init_c) begin
      // init cycle, nothing observed
    end else if (hdr_c < 0) begin
      if (tin) hdr_c = cyc;
    end else if (in_last_c < 0) begin
      if (tin) begin
        if (rem > 0) begin acc++; counted = 1; end
        else err_m = 1;
      end
      if (tout && del != n_m) del++;
      if (acc == n_m) in_last_c = cyc;
    end else if (f_c < 0) begin
      if (tin) err_m = 1;
      if (del == n_m) f_c = cyc;
      else if (tout) begin
        del++;
        if (del == n_m) f_c = cyc;
      end
    end else begin
      if (tin) err_m = 1;
      if (cyc == f_c + D) begin pass_on = 0; done_m = 1; end
    end

    if (tin && src_left > 0) src_left--;
    if (counted) pending++;
    if (tout && pending > 0) pending--;
    if (tout && del == hold_at && hold_left == 0) hold_left = 6;

    rdy_n = !stop_o;
    @(posedge clk);
    #1;
    stage_rdy = rdy_n;
    cyc++;
  endtask

  task automatic begin_pass(input int tot, input int words, input int sp, input int op, input int hat);
    tot_drv = tot; total_num_turns_i = W'(tot);
    src_left = words; pending = 0; spct = sp; opct = op;
    hold_at = hat; hold_left = 0;
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
  endtask

  task automatic run_pass(input int tot, input int words, input int sp, input int op, input int hat);
    begin_pass(tot, words, sp, op, hat);
    for (int k = 0; k < 400 && !(!pass_on && done_m); k++) cycle();
    chk("pass_done", 32'(done_o), 1);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    in_valid_i = 1'b0; in_ready_i = 1'b0; out_valid_i = 1'b0; out_ready_i = 1'b0;
    total_num_turns_i = '0;
    model_reset();
    tot_drv = 0; src_left = 0; pending = 0; spct = 100; opct = 100;
    hold_at = -1; hold_left = 0; n_init = 0; stage_rdy = 0; force_ld = 0;
    repeat (2) @(posedge clk);
    #1;
    cycle(); cycle();
    rst_n = 1'b1;
    cycle(); cycle();

    // header 3, three payload words, downstream always ready
    n_init = 0;
    run_pass(3, 4, 100, 100, -1);
    chk("t1_init_pulses", n_init, 1);
    chk("t1_in_cnt",  32'(in_cnt_o),  3);
    chk("t1_out_cnt", 32'(out_cnt_o), 3);
    chk("t1_err",     32'(err_o),     0);
    cycle(); cycle();

    // header 3, upstream offers five payload words back to back
    run_pass(3, 6, 100, 100, -1);
    chk("t2_in_cnt", 32'(in_cnt_o), 3);
    chk("t2_err",    32'(err_o),    0);
    src_left = 0;
    cycle();

    // header 0, clean
    run_pass(0, 1, 100, 100, -1);
    chk("t3_in_cnt", 32'(in_cnt_o), 0);
    chk("t3_err",    32'(err_o),    0);

    // header 0 with a word forced in during LOAD
    force_ld = 1;
    run_pass(0, 2, 100, 100, -1);
    force_ld = 0;
    src_left = 0;
    chk("t4_err",    32'(err_o),    1);
    chk("t4_in_cnt", 32'(in_cnt_o), 0);
    cycle();

    // header 4, downstream stalls 6 cycles after the 2nd delivery
    run_pass(4, 5, 100, 100, 2);
    chk("t5_out_cnt", 32'(out_cnt_o), 4);
    hold_at = -1;
    cycle();

    // abort in RUN at in_cnt 2
    begin_pass(5, 6, 60, 100, -1);
    for (int k = 0; k < 200 &&
         !(pass_on && hdr_c >= 0 && in_last_c < 0 && cyc > hdr_c + 1 && acc == 2); k++)
      cycle();
    chk("t6_reach_in2", 32'(in_cnt_o), 2);
    abort_i = 1'b1;
    cycle();
    abort_i = 1'b0;
    src_left = 0;
    cycle();
    chk("t6_abort_busy", 32'(busy_o),   0);
    chk("t6_abort_stop", 32'(stop_o),   1);
    chk("t6_abort_cnt",  32'(in_cnt_o), 2);
    run_pass(2, 3, 100, 100, -1);
    chk("t6_clean_in",  32'(in_cnt_o),  2);
    chk("t6_clean_out", 32'(out_cnt_o), 2);

    // reset during DRAIN, then a pass and a restart from DONE
    begin_pass(2, 3, 100, 100, -1);
    for (int k = 0; k < 200 && !(pass_on && f_c >= 0 && cyc > f_c); k++) cycle();
    chk("t7_in_drain", 32'(busy_o), 1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    src_left = 0; pending = 0;
    cycle();
    chk("t7_rst_busy", 32'(busy_o),   0);
    chk("t7_rst_cnt",  32'(in_cnt_o), 0);
    run_pass(3, 4, 100, 100, -1);
    run_pass(1, 2, 100, 100, -1);
    chk("t7_restart_in", 32'(in_cnt_o), 1);

    // randomized passes
    for (int p = 0; p < 25; p++) begin
      int t;
      t = $urandom_range(0, 8);
      run_pass(t, t + 1 + $urandom_range(0, 2), $urandom_range(40, 100),
               $urandom_range(30, 100), -1);
      src_left = 0;
      repeat ($urandom_range(0, 3)) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
